input_event_queue: RTL and testbench

- Collects single-cycle user-input pulses (edge-detected pushbuttons plus decoded rotary-wheel events) and serialises them into a FIFO of 3-bit event codes.
- Sits between the pushbutton edge detector / rotary decoder and the CPU's memory-mapped I/O, so software never misses a press that arrives while it is busy.
- Simultaneous events are arbitrated one per cycle. Event loss is counted.

---
 rtl/input_event_queue_if.sv | 35 +++
 rtl/input_event_queue.sv | 96 +++++++++
 tb/tb_input_event_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/input_event_queue_if.sv
// Event-queue bundle: pulse sources and controls from the producer side, plus the
// consumer-facing read port and status outputs.
interface input_event_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              rotary_push;
  logic              button_c;
  logic              button_n;
  logic              button_e;
  logic              button_w;
  logic              button_s;
  logic              rotary_event;
  logic              rotary_left;
  logic              rd_ready;
  logic              clear_drop;
  logic              rd_valid;
  logic [2:0]        rd_data;
  logic [AW:0]       count;
  logic [DROP_W-1:0] dropped;

  modport master (
    output rotary_push, button_c, button_n, button_e, button_w, button_s,
           rotary_event, rotary_left, rd_ready, clear_drop,
    input  rd_valid, rd_data, count, dropped
  );

  modport slave (
    input  rotary_push, button_c, button_n, button_e, button_w, button_s,
           rotary_event, rotary_left, rd_ready, clear_drop,
    output rd_valid, rd_data, count, dropped
  );
endinterface

// File: rtl/input_event_queue.sv
// Serialises one-cycle user-input pulses into a FIFO of 3-bit event codes; one
// pending bit per source, lowest code wins, collisions on a pending source are counted.
module input_event_queue #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input_event_queue_if.slave    evq_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DROP_W + 4;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [7:0]        src;
  logic [7:0]        pending_q, pending_d;
  logic [7:0]        grant;
  logic [7:0]        collide;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              rd_valid_q;
  logic [2:0]        mem_q [DEPTH];
  logic              pop;
  logic              push_ok;
  logic              push;
  logic [2:0]        push_code;
  logic [3:0]        n_drop;
  logic [SW-1:0]     drop_sum;

  assign src = {evq_if.rotary_event &  evq_if.rotary_left,
                evq_if.rotary_event & ~evq_if.rotary_left,
                evq_if.button_s, evq_if.button_w, evq_if.button_e,
                evq_if.button_n, evq_if.button_c, evq_if.rotary_push};

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    pop       = rd_valid_q & evq_if.rd_ready;
    push_ok   = (count_q < CW'(DEPTH)) | pop;
    grant     = push_ok ? (pending_q & (~pending_q + 8'd1)) : 8'd0;
    push      = |grant;
    push_code = 3'd0;
    n_drop    = 4'd0;
    for (int k = 0; k < 8; k++) begin
      if (grant[k]) push_code = 3'(k);
    end
    // A fresh pulse on the source being granted re-arms its bit rather than colliding.
    pending_d = (pending_q & ~grant) | src;
    collide   = src & pending_q & ~grant;
    for (int k = 0; k < 8; k++) begin
      n_drop = n_drop + {3'd0, collide[k]};
    end
    drop_sum = {4'd0, dropped_q} + SW'(n_drop);
    if (evq_if.clear_drop)          dropped_d = '0;
    else if (drop_sum > SW'(DROP_MAX)) dropped_d = DROP_MAX;
    else                            dropped_d = drop_sum[DROP_W-1:0];
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      dropped_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      dropped_q  <= dropped_d;
      rd_valid_q <= (count_d != '0);
    end
  end

  // NOTE: the storage is reset because rd_data reads it directly and must be 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 3'd0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign evq_if.rd_valid = rd_valid_q;
  assign evq_if.rd_data  = mem_q[rd_ptr_q];
  assign evq_if.count    = count_q;
  assign evq_if.dropped  = dropped_q;
endmodule

// File: tb/tb_input_event_queue.sv
// Self-checking bench: directed scenarios plus random traffic, all compared against
// a queue-based reference model of the event queue.
module tb_input_event_queue;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int DMAX   = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_event_queue_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) evq ();

  input_event_queue #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .evq_if (evq)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pend;
  int         m_q[$];
  int         m_drop;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend = '0;
    m_q.delete();
    m_drop = 0;
  endfunction

  // One clock edge of the queue, expressed as source/FIFO rules rather than hardware.
  function automatic void model_edge(input logic [7:0] s, input logic rdy, input logic clr);
    bit pop = (m_q.size() > 0) && rdy;
    int g   = -1;
    int nd  = 0;
    if (m_q.size() < DEPTH || pop)
      for (int k = 0; k < 8; k++) if (m_pend[k] && g < 0) g = k;
    for (int k = 0; k < 8; k++) if (s[k] && m_pend[k] && k != g) nd++;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
    end
    m_pend = m_pend | s;
    if (clr)                  m_drop = 0;
    else if (m_drop + nd > DMAX) m_drop = DMAX;
    else                      m_drop = m_drop + nd;
  endfunction

  task automatic compare_model();
    check("valid",   evq.rd_valid, m_q.size() != 0);
    check("count",   evq.count,    m_q.size());
    check("dropped", evq.dropped,  m_drop);
    if (m_q.size() > 0) check("data", evq.rd_data, m_q[0]);
  endtask

  task automatic drive_idle();
    evq.rotary_push = 0; evq.button_c = 0; evq.button_n = 0; evq.button_e = 0;
    evq.button_w = 0; evq.button_s = 0; evq.rotary_event = 0; evq.rotary_left = 0;
    evq.rd_ready = 0; evq.clear_drop = 0;
  endtask

  // Called at a falling edge: drive one cycle of stimulus, advance, then compare.
  task automatic step(input logic [7:0] ev, input logic rdy, input logic clr);
    logic [7:0] s;
    s = ev;
    if (s[7]) s[6] = 1'b0;
    evq.rotary_push  = s[0];
    evq.button_c     = s[1];
    evq.button_n     = s[2];
    evq.button_e     = s[3];
    evq.button_w     = s[4];
    evq.button_s     = s[5];
    evq.rotary_event = s[6] | s[7];
    evq.rotary_left  = s[7] ? 1'b1 : (s[6] ? 1'b0 : 1'($urandom_range(0, 1)));
    evq.rd_ready     = rdy;
    evq.clear_drop   = clr;
    @(posedge clk);
    model_edge(s, rdy, clr);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(8'h00, rdy, 1'b0);
  endtask

  initial begin
    drive_idle();
    model_reset();
    evq.button_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid",   evq.rd_valid, 0);
    check("rst_data",    evq.rd_data,  0);
    check("rst_count",   evq.count,    0);
    check("rst_dropped", evq.dropped,  0);
    evq.button_n = 1'b0;
    rst = 1'b1;

    // Single button_n pulse, then one pop.
    idle(9, 1'b0);
    step(8'h04, 1'b0, 1'b0);
    check("s1_lat_valid", evq.rd_valid, 0);
    step(8'h00, 1'b0, 1'b0);
    check("s1_valid", evq.rd_valid, 1);
    check("s1_data",  evq.rd_data,  2);
    check("s1_count", evq.count,    1);
    step(8'h00, 1'b1, 1'b0);
    check("s1_pop_count", evq.count,    0);
    check("s1_pop_valid", evq.rd_valid, 0);

    // Rotary left then right, drained in arrival order.
    step(8'h80, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(8'h40, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("s2_count", evq.count,   2);
    check("s2_head7", evq.rd_data, 7);
    step(8'h00, 1'b1, 1'b0);
    check("s2_head6", evq.rd_data, 6);
    step(8'h00, 1'b1, 1'b0);
    check("s2_empty", evq.count, 0);

    // Three simultaneous sources arbitrate lowest-code first.
    step(8'h23, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("s3_count",   evq.count,   3);
    check("s3_dropped", evq.dropped, 0);
    check("s3_head0",   evq.rd_data, 0);
    step(8'h00, 1'b1, 1'b0);
    check("s3_head1",   evq.rd_data, 1);
    step(8'h00, 1'b1, 1'b0);
    check("s3_head5",   evq.rd_data, 5);
    step(8'h00, 1'b1, 1'b0);
    check("s3_empty",   evq.count, 0);

    // Fill to full, then collide on the stalled source.
    repeat (8) begin
      step(8'h08, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    check("s4_full", evq.count, 8);
    repeat (3) step(8'h08, 1'b0, 1'b0);
    check("s4_dropped", evq.dropped, 2);
    step(8'h00, 1'b1, 1'b0);
    check("s4_push_pop_count", evq.count, 8);

    // Saturation, then clear with a concurrent collision.
    repeat (300) step(8'h08, 1'b0, 1'b0);
    check("s5_sat", evq.dropped, 255);
    step(8'h08, 1'b0, 1'b1);
    check("s5_clear", evq.dropped, 0);
    idle(12, 1'b1);
    check("s5_drained", evq.count, 0);

    // Asynchronous reset with entries queued and sources pending.
    repeat (5) begin
      step(8'h01, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
    end
    step(8'h12, 1'b0, 1'b0);
    check("s6_count", evq.count, 5);
    #2 rst = 1'b0;
    #1;
    check("s6_rst_valid",   evq.rd_valid, 0);
    check("s6_rst_data",    evq.rd_data,  0);
    check("s6_rst_count",   evq.count,    0);
    check("s6_rst_dropped", evq.dropped,  0);
    model_reset();
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
    step(8'h10, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("s6_data",  evq.rd_data, 4);
    check("s6_count1", evq.count,  1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ev;
      for (int k = 0; k < 8; k++) ev[k] = ($urandom_range(0, 3) == 0);
      step(ev, ($urandom_range(0, 2) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
